pcileech_bar_rsp_arbiter: RTL
=============================

PCILEECH_BAR_RSP_ARBITER -- requirements
Module: pcileech_bar_rsp_arbiter

Interface
REQ-001 Parameters SHALL be:
  NSRC   4   number of BAR read-response sources (2..8)
  DEPTH  4   per-source response FIFO depth (power of 2, >=2)
REQ-002 Ports SHALL be:
  clk        in   1          single clock; all logic on rising edge
  rst        in   1          asynchronous, active-low reset
  in_valid   in   NSRC       per-source response strobe, 1-cycle pulse, no backpressure
  in_ctx     in   88*NSRC    per-source response context, slice i = [i*88+:88]
  in_data    in   32*NSRC    per-source response data, slice i = [i*32+:32]
  out_valid  out  1          merged response valid
  out_ready  in   1          downstream accepts when out_valid && out_ready
  out_ctx    out  88         merged response context
  out_data   out  32         merged response data
  out_src    out  3          index of source that produced current output
  ovf        out  NSRC       sticky per-source overflow flag
  ovf_clr    in   NSRC       per-source overflow clear pulse
  busy       out  1          any FIFO non-empty or out_valid high

Function
REQ-003 Each source SHALL own a DEPTH-entry FIFO storing {ctx, data}; in_valid[i] pushes in_ctx/in_data slice i at the clock edge.
REQ-004 Push SHALL be accepted when FIFO level < DEPTH, or when level == DEPTH and that FIFO is popped in the same cycle (level unchanged).
REQ-005 A rejected push SHALL drop the beat, leave FIFO contents unchanged, and set ovf[i] at that edge.
REQ-006 ovf[i] SHALL stay set until ovf_clr[i]; simultaneous set and clear SHALL leave ovf[i] = 1.
REQ-007 Output register SHALL load when (!out_valid || out_ready) and at least one FIFO is non-empty; otherwise out_valid/out_ctx/out_data/out_src SHALL hold.
REQ-008 Out_valid SHALL drop to 0 after an accepted beat when no FIFO is non-empty; out_* data SHALL not change while out_valid && !out_ready.
REQ-009 Arbitration SHALL be round-robin: search begins at (last_grant+1) mod NSRC; first non-empty FIFO wins; last_grant updates to winner on each load only.
REQ-010 Winner FIFO SHALL pop in the same cycle the output register loads.
REQ-011 Latency SHALL be 2 cycles: in_valid at cycle N with empty FIFOs, free output -> out_valid high in cycle N+2.
REQ-012 Sustained throughput SHALL be one beat per cycle while out_ready = 1 and any FIFO non-empty.
REQ-013 Per-source ordering SHALL be preserved; cross-source order is defined only by REQ-009.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH; level SHALL be 0..DEPTH inclusive.
REQ-015 busy SHALL be combinational OR of all FIFO non-empty flags and out_valid.

Reset
REQ-016 rst low SHALL asynchronously clear all FIFO levels/pointers, ovf = 0, out_valid = 0, out_ctx = 0, out_data = 0, out_src = 0, last_grant = NSRC-1 (source 0 highest priority first).
REQ-017 Reset mid-operation SHALL discard all queued and presented beats; no beat SHALL appear after reset release unless pushed after release.
REQ-018 in_valid during reset SHALL be ignored.

Verification
REQ-019 Single beat: in_valid[2] ctx=0x5A.., data=0xAABB0001 at cycle 10, out_ready=1 -> out_valid cycle 12, out_data=0xAABB0001, out_src=2, busy low at cycle 13.
REQ-020 Round-robin: all four sources pulse in cycle 0 with data 0x10..0x13, out_ready=1 -> outputs in order src 0,1,2,3 on cycles 2..5, back-to-back.
REQ-021 Backpressure/overflow: out_ready=0, source 1 pulses 6 times -> first beat in output register, next 4 in FIFO, 6th dropped, ovf[1]=1; release out_ready -> exactly 5 beats, in push order.
REQ-022 Full push+pop: FIFO 0 full, out_ready=1 with src 0 winning, in_valid[0] same cycle -> accepted, ovf[0] stays 0, level stays DEPTH.
REQ-023 Overflow clear race: ovf_clr[3] and overflowing push on source 3 same cycle -> ovf[3]=1; clear alone next cycle -> ovf[3]=0.
REQ-024 Reset mid-stream: 3 beats queued, out_valid=1, assert rst for 1 cycle -> out_valid=0 immediately, busy=0, no output after release until new push.

Source files
------------

// File: rtl/pcileech_bar_rsp_arbiter.sv
// BAR read-response merger.
// Every response source owns a small FIFO of {ctx, data} beats. A round-robin
// arbiter drains those FIFOs into one registered output stage that has a
// valid/ready handshake. If a source pushes into a FIFO that is already full,
// the beat is dropped and a sticky overflow flag is raised for that source.

// Response FIFO for one source. It also holds that source's sticky overflow flag.
module pcileech_bar_rsp_fifo #(
    parameter int W     = 120,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    input  logic         ovf_clr,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          acc;
    logic          do_pop;

    assign full   = (level == (AW+1)'(DEPTH));
    assign empty  = (level == '0);
    // When the FIFO is full, a pop in the same cycle makes room for the push.
    assign acc    = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    // Pointer and level bookkeeping. DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({acc, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array. It is never read past the level, so it needs no reset.
    always_ff @(posedge clk) begin
        if (acc)
            mem[wr_ptr] <= din;
    end

    // Sticky overflow flag. If a drop and a clear happen in the same cycle, the set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (push && !acc)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
endmodule

module pcileech_bar_rsp_arbiter #(
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   in_valid,
    input  logic [88*NSRC-1:0] in_ctx,
    input  logic [32*NSRC-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [87:0]       out_ctx,
    output logic [31:0]       out_data,
    output logic [2:0]        out_src,
    output logic [NSRC-1:0]   ovf,
    input  logic [NSRC-1:0]   ovf_clr,
    output logic              busy
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef struct packed {
        logic [87:0] ctx;
        logic [31:0] data;
    } rsp_t;

    rsp_t [NSRC-1:0] fifo_dout;
    logic [NSRC-1:0] fifo_empty;
    logic [NSRC-1:0] fifo_pop;
    logic [2:0]      last_grant;
    logic [2:0]      grant;
    logic            grant_vld;
    logic            load;
    int              idx;

    // One FIFO per source.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        rsp_t din;
        assign din.ctx  = in_ctx[i*88 +: 88];
        assign din.data = in_data[i*32 +: 32];

        pcileech_bar_rsp_fifo #(.W($bits(rsp_t)), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (in_valid[i]),
            .pop     (fifo_pop[i]),
            .din     (din),
            .ovf_clr (ovf_clr[i]),
            .dout    (fifo_dout[i]),
            .empty   (fifo_empty[i]),
            .ovf     (ovf[i])
        );
    end

    // Round-robin search. It starts at the source after the last winner, and the first non-empty FIFO wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(last_grant) + 1 + k) % NSRC;
            if (!grant_vld && !fifo_empty[idx[SW-1:0]]) begin
                grant_vld = 1'b1;
                grant     = 3'(idx);
            end
        end
    end

    // The output register loads when it is free, or when it is being drained this cycle.
    assign load = grant_vld && (!out_valid || out_ready);

    // The winning FIFO pops in the same cycle the output register captures its head.
    always_comb begin
        fifo_pop = '0;
        if (load)
            fifo_pop[grant[SW-1:0]] = 1'b1;
    end

    // Output stage. The payload holds while it is stalled. Valid drops once a beat is accepted and nothing is waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_ctx    <= '0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= 3'(NSRC - 1);
        end else if (load) begin
            out_valid  <= 1'b1;
            out_ctx    <= fifo_dout[grant[SW-1:0]].ctx;
            out_data   <= fifo_dout[grant[SW-1:0]].data;
            out_src    <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    assign busy = (~fifo_empty != '0) || out_valid;
endmodule
